// File: rtl/cnn_pkg.sv
// Shared CNN-side definitions: streamer state encoding and image/class defaults
// matching the CNN core.
package cnn_pkg;

  localparam int unsigned CNN_IMG_W = 28;
  localparam int unsigned CNN_IMG_H = 28;
  localparam int unsigned CNN_PIX_W = 8;
  localparam int unsigned CNN_CLS_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_STREAM,
    ST_WAIT_RES
  } fs_state_e;

endpackage

// File: rtl/frame_buf_ram.sv
// Frame buffer: one write port, one read port, registered read data (1-cycle
// latency), contents not reset. Read data holds while rd_en_i is low.
module frame_buf_ram #(
  parameter  int unsigned DW    = 8,
  parameter  int unsigned DEPTH = 3136,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cnn_frame_streamer.sv
// Multi-frame pixel source for the CNN core: streams buffered images with
// valid/ready and SOF/EOF, waits for each classification and logs it.
module cnn_frame_streamer
  import cnn_pkg::*;
#(
  parameter  int unsigned PIX_W    = CNN_PIX_W,
  parameter  int unsigned IMG_W    = CNN_IMG_W,
  parameter  int unsigned IMG_H    = CNN_IMG_H,
  parameter  int unsigned N_FRAMES = 4,
  parameter  int unsigned CLS_W    = CNN_CLS_W,
  localparam int unsigned FRM_PIX  = IMG_W * IMG_H,
  localparam int unsigned AW       = $clog2(N_FRAMES * FRM_PIX),
  localparam int unsigned FW       = $clog2(N_FRAMES) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             start,
  input  logic [FW-1:0]    num_frames,
  input  logic             loop,
  input  logic             stop,
  output logic             out_val,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eof,
  input  logic             out_rdy,
  input  logic             res_val,
  input  logic [CLS_W-1:0] res_class,
  output logic             log_val,
  output logic [FW-1:0]    log_frame,
  output logic [CLS_W-1:0] log_class,
  output logic             busy,
  output logic             err_unexp
);

  localparam int unsigned   PW       = $clog2(FRM_PIX);
  localparam logic [PW-1:0] PIX_LAST = PW'(FRM_PIX - 1);
  localparam logic [FW-1:0] NF_MAX   = FW'(N_FRAMES);

  fs_state_e        state_q, state_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [FW-1:0]    frames_q, frames_d;
  logic [PW-1:0]    pix_q, pix_d, pix_nxt, rd_pix;
  logic             loop_q, loop_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;
  logic             out_val_q, out_val_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             log_val_q, log_val_d;
  logic [FW-1:0]    log_frame_q, log_frame_d;
  logic [CLS_W-1:0] log_class_q, log_class_d;
  logic             err_q, err_d;
  logic             start_ok, rd_en, ram_we;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_data;

  assign start_ok = start && (num_frames != '0) && (num_frames <= NF_MAX);
  assign pix_nxt  = pix_q + PW'(1);
  assign rd_addr  = AW'(frame_q) * AW'(FRM_PIX) + AW'(rd_pix);
  assign ram_we   = wr_en && (state_q == ST_IDLE);

  frame_buf_ram #(
    .DW    (PIX_W),
    .DEPTH (N_FRAMES * FRM_PIX)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    frames_d    = frames_q;
    pix_d       = pix_q;
    loop_d      = loop_q;
    stop_d      = stop_q;
    done_d      = done_q;
    out_val_d   = out_val_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    log_val_d   = 1'b0;
    log_frame_d = log_frame_q;
    log_class_d = log_class_q;
    err_d       = err_q;
    rd_en       = 1'b0;
    rd_pix      = pix_q;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_PREFETCH;
          frame_d  = '0;
          pix_d    = '0;
          frames_d = num_frames;
          loop_d   = loop;
          err_d    = 1'b0;
        end
      end
      ST_PREFETCH: begin
        rd_en     = 1'b1;
        state_d   = ST_STREAM;
        out_val_d = 1'b1;
        sof_d     = 1'b1;
        eof_d     = (pix_q == PIX_LAST);
      end
      ST_STREAM: begin
        // The RAM read register is the data stage; reading only on a transfer
        // keeps out_data stable through a stall.
        if (out_rdy) begin
          if (eof_q) begin
            state_d   = ST_WAIT_RES;
            out_val_d = 1'b0;
            sof_d     = 1'b0;
            eof_d     = 1'b0;
          end else begin
            rd_en  = 1'b1;
            rd_pix = pix_nxt;
            pix_d  = pix_nxt;
            sof_d  = 1'b0;
            eof_d  = (pix_nxt == PIX_LAST);
          end
        end
      end
      ST_WAIT_RES: begin
        // Result is logged first; the pass decision follows one cycle later.
        if (done_q) begin
          done_d = 1'b0;
          pix_d  = '0;
          if (stop_q || stop) begin
            state_d = ST_IDLE;
          end else if (frame_q + FW'(1) < frames_q) begin
            frame_d = frame_q + FW'(1);
            state_d = ST_PREFETCH;
          end else if (loop_q) begin
            frame_d = '0;
            state_d = ST_PREFETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (res_val) begin
          done_d      = 1'b1;
          log_val_d   = 1'b1;
          log_frame_d = frame_q;
          log_class_d = res_class;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (res_val && (state_q != ST_WAIT_RES)) err_d = 1'b1;

    if (state_d == ST_IDLE)                 stop_d = 1'b0;
    else if (state_q != ST_IDLE && stop)    stop_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      frames_q    <= '0;
      pix_q       <= '0;
      loop_q      <= 1'b0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      out_val_q   <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      log_val_q   <= 1'b0;
      log_frame_q <= '0;
      log_class_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      frames_q    <= frames_d;
      pix_q       <= pix_d;
      loop_q      <= loop_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
      out_val_q   <= out_val_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      log_val_q   <= log_val_d;
      log_frame_q <= log_frame_d;
      log_class_q <= log_class_d;
      err_q       <= err_d;
    end
  end

  assign out_val   = out_val_q;
  assign out_data  = out_val_q ? rd_data : '0;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign log_val   = log_val_q;
  assign log_frame = log_frame_q;
  assign log_class = log_class_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_unexp = err_q;

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Directed bench for cnn_frame_streamer: guard-vector table plus frame,
// back-pressure, multi-frame, loop/stop and reset sequences against a buffer model.
module tb_cnn_frame_streamer;

  localparam int unsigned NPIX = 784;
  localparam int unsigned NFR  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        start = 1'b0;
  logic [2:0]  num_frames = '0;
  logic        loop = 1'b0;
  logic        stop = 1'b0;
  logic        out_val;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        out_rdy = 1'b1;
  logic        res_val = 1'b0;
  logic [3:0]  res_class = '0;
  logic        log_val;
  logic [2:0]  log_frame;
  logic [3:0]  log_class;
  logic        busy;
  logic        err_unexp;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] model [NPIX*NFR];

  typedef struct {
    logic       st;
    logic [2:0] nf;
    logic       rv;
    logic       exp_busy;
    logic       exp_err;
  } gvec_t;
  gvec_t gv [7];

  always #5 clk = ~clk;

  cnn_frame_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .num_frames (num_frames),
    .loop       (loop),
    .stop       (stop),
    .out_val    (out_val),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_rdy    (out_rdy),
    .res_val    (res_val),
    .res_class  (res_class),
    .log_val    (log_val),
    .log_frame  (log_frame),
    .log_class  (log_class),
    .busy       (busy),
    .err_unexp  (err_unexp)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_frame(input int f, input int fill);
    for (int i = 0; i < int'(NPIX); i++) begin
      logic [7:0] d;
      d = (fill < 0) ? 8'(i % 256) : 8'(fill);
      model[f*NPIX + i] = d;
      wr_en = 1'b1; wr_addr = 12'(f*NPIX + i); wr_data = d;
      tick;
    end
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] nf, input logic lp);
    num_frames = nf; loop = lp; start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_noval", out_val, 0);
    tick;
    chk("start_sof", {out_val, out_sof}, 2'b11);
  endtask

  // Consumes pixels [from, lim) of frame f, checking data, SOF/EOF and stall hold.
  task automatic recv_frame(input int f, input bit bp, input int from, input int lim);
    int idx = from;
    int bad = 0;
    int cyc = 0;
    logic [7:0] held = '0;
    bit stalled = 0;
    while (idx < lim && cyc < 6000) begin
      if (out_val) begin
        if (stalled && out_data !== held) bad++;
        if (out_data !== model[f*NPIX + idx] || out_sof !== (idx == 0) ||
            out_eof !== (idx == int'(NPIX) - 1)) bad++;
        out_rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        stalled = !out_rdy;
        held = out_data;
        if (out_rdy) idx++;
      end else begin
        bad++;
      end
      tick;
      cyc++;
    end
    out_rdy = 1'b1;
    chk($sformatf("frame%0d_pixels", f), bad, 0);
    chk($sformatf("frame%0d_count", f), idx, lim);
    if (lim == int'(NPIX)) chk("eof_val_drop", out_val, 0);
  endtask

  task automatic send_res(input logic [3:0] cls, input logic [2:0] fr, input bit cont);
    int idle_bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (out_val || !busy || log_val) idle_bad++;
      tick;
    end
    chk("wait_res_idle", idle_bad, 0);
    res_val = 1'b1; res_class = cls;
    tick;
    res_val = 1'b0;
    chk("log_val", log_val, 1);
    chk("log_frame", log_frame, 32'(fr));
    chk("log_class", log_class, 32'(cls));
    tick;
    chk("log_pulse", log_val, 0);
    if (cont) begin
      chk("res_noval", out_val, 0);
      chk("res_busy", busy, 1);
      tick;
      chk("res_next_sof", {out_val, out_sof}, 2'b11);
    end else begin
      chk("res_to_idle", busy, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    gv[0] = '{st: 1'b1, nf: 3'd0, rv: 1'b0, exp_busy: 1'b0, exp_err: 1'b0};
    gv[1] = '{st: 1'b1, nf: 3'd5, rv: 1'b0, exp_busy: 1'b0, exp_err: 1'b0};
    gv[2] = '{st: 1'b1, nf: 3'd7, rv: 1'b0, exp_busy: 1'b0, exp_err: 1'b0};
    gv[3] = '{st: 1'b0, nf: 3'd2, rv: 1'b1, exp_busy: 1'b0, exp_err: 1'b1};
    gv[4] = '{st: 1'b1, nf: 3'd0, rv: 1'b0, exp_busy: 1'b0, exp_err: 1'b1};
    gv[5] = '{st: 1'b1, nf: 3'd4, rv: 1'b0, exp_busy: 1'b1, exp_err: 1'b0};
    gv[6] = '{st: 1'b1, nf: 3'd1, rv: 1'b0, exp_busy: 1'b1, exp_err: 1'b0};

    tick; tick;
    chk("rst_out_val", out_val, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sof_eof", {out_sof, out_eof}, 0);
    chk("rst_log", {log_val, log_frame, log_class}, 0);
    chk("rst_busy_err", {busy, err_unexp}, 0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 7; i++) begin
      start = gv[i].st; num_frames = gv[i].nf; res_val = gv[i].rv;
      tick;
      start = 1'b0; res_val = 1'b0;
      chk($sformatf("guard%0d_busy", i), busy, 32'(gv[i].exp_busy));
      chk($sformatf("guard%0d_err", i), err_unexp, 32'(gv[i].exp_err));
      chk($sformatf("guard%0d_nolog", i), log_val, 0);
      if (gv[i].exp_busy) begin
        rst_n = 1'b0; tick; rst_n = 1'b1; tick;
      end
    end

    // Ramp frame, single pass
    load_frame(0, -1);
    do_start(3'd1, 1'b0);
    recv_frame(0, 0, 0, NPIX);
    send_res(4'd3, 3'd0, 0);

    // Stray result mid-stream plus a write attempt while busy
    do_start(3'd1, 1'b0);
    out_rdy = 1'b0; res_val = 1'b1; res_class = 4'd9;
    wr_en = 1'b1; wr_addr = 12'd5; wr_data = 8'hEE;
    tick;
    res_val = 1'b0; wr_en = 1'b0;
    chk("err_set", err_unexp, 1);
    chk("err_nolog", log_val, 0);
    chk("stall_hold_sof", {out_val, out_sof, out_data}, {2'b11, 8'h00});
    recv_frame(0, 0, 0, NPIX);
    send_res(4'd2, 3'd0, 0);
    chk("err_sticky", err_unexp, 1);

    // Back-pressure
    do_start(3'd1, 1'b0);
    chk("err_clr_on_start", err_unexp, 0);
    recv_frame(0, 1, 0, NPIX);
    send_res(4'd5, 3'd0, 0);

    // Reset mid-frame, then replay from pixel 0 (also shows address 5 unchanged)
    do_start(3'd1, 1'b0);
    recv_frame(0, 0, 0, 400);
    rst_n = 1'b0;
    tick;
    chk("midrst_val_data", {out_val, out_data}, 0);
    chk("midrst_sof_eof", {out_sof, out_eof}, 0);
    chk("midrst_busy_log", {busy, log_val}, 0);
    rst_n = 1'b1;
    tick;
    chk("midrst_idle", busy, 0);
    do_start(3'd1, 1'b0);
    recv_frame(0, 0, 0, NPIX);
    send_res(4'd4, 3'd0, 0);

    // Multi-frame pass
    for (int f = 0; f < int'(NFR); f++) load_frame(f, 16 * (f + 1));
    do_start(3'd4, 1'b0);
    for (int f = 0; f < int'(NFR); f++) begin
      recv_frame(f, 0, 0, NPIX);
      send_res(4'(f + 1), 3'(f), f < int'(NFR) - 1);
    end

    // Looping pass stopped during the third frame
    do_start(3'd2, 1'b1);
    recv_frame(0, 0, 0, NPIX);
    send_res(4'd6, 3'd0, 1);
    recv_frame(1, 0, 0, NPIX);
    send_res(4'd7, 3'd1, 1);
    recv_frame(0, 0, 0, 100);
    stop = 1'b1;
    recv_frame(0, 0, 100, NPIX);
    stop = 1'b0;
    send_res(4'd8, 3'd0, 0);

    // Stop latch must not survive into the next pass
    do_start(3'd2, 1'b0);
    recv_frame(0, 0, 0, NPIX);
    send_res(4'd1, 3'd0, 1);
    recv_frame(1, 0, 0, NPIX);
    send_res(4'd2, 3'd1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_frame_streamer.md
# cnn_frame_streamer

Synthesizable frame source for the CNN core. It holds up to `N_FRAMES` images in an internal buffer and streams each image pixel-by-pixel into the CNN input with a valid/ready handshake and frame markers. It waits for the CNN's classification after every frame and logs each result with its frame index. The block sits between the host load path and the `CNN` instance, and replaces free-running pixel feeding with a back-pressured, multi-frame, optionally looping source.

## Interface
Parameters:
- `PIX_W`, 8: pixel width.
- `IMG_W`, 28: image width in pixels.
- `IMG_H`, 28: image height in pixels.
- `N_FRAMES`, 4: frame buffer depth, in frames.
- `CLS_W`, 4: class/decision width.
- Derived: `FRM_PIX` = `IMG_W*IMG_H`; `AW` = clog2(`N_FRAMES*FRM_PIX`); `FW` = clog2(`N_FRAMES`)+1.

Ports:
- `clk`  in  1  clock, one clock domain only.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  AW  buffer write address (frame*`FRM_PIX` + row*`IMG_W` + col).
- `wr_data`  in  PIX_W  buffer write data.
- `start`  in  1  single-cycle start request.
- `num_frames`  in  FW  frames per pass, legal range 1..`N_FRAMES`; sampled on an accepted `start`.
- `loop`  in  1  repeat passes until `stop`; sampled on an accepted `start`.
- `stop`  in  1  finish the current frame, then return to idle.
- `out_val`  out  1  pixel valid.
- `out_data`  out  PIX_W  pixel.
- `out_sof`  out  1  first pixel of a frame.
- `out_eof`  out  1  last pixel of a frame.
- `out_rdy`  in  1  consumer ready.
- `res_val`  in  1  CNN result strobe (the CNN's `out_val`).
- `res_class`  in  CLS_W  CNN decision.
- `log_val`  out  1  one-cycle result log strobe.
- `log_frame`  out  FW  frame index of the logged result.
- `log_class`  out  CLS_W  logged decision.
- `busy`  out  1  high in any state except IDLE.
- `err_unexp`  out  1  sticky; a result arrived outside WAIT_RES.

## Operation
- States: IDLE, PREFETCH, STREAM, WAIT_RES.
- IDLE → PREFETCH on `start` with `num_frames` in 1..`N_FRAMES`.
  - `start` is ignored when `num_frames` is 0, when `num_frames` > `N_FRAMES`, or when not in IDLE.
  - An accepted `start` sets frame index 0 and pixel index 0, and clears `err_unexp`.
- PREFETCH: issues the synchronous buffer read of pixel 0 (1-cycle read latency), then enters STREAM.
- STREAM: the output register holds one pixel.
  - A transfer occurs when `out_val && out_rdy`. On a transfer the next pixel is already being read, so back-to-back transfers give one pixel per cycle.
  - While `out_val && !out_rdy`, `out_data`, `out_sof` and `out_eof` are held stable and `out_val` stays high.
  - When the transfer with `out_eof` completes, the block enters WAIT_RES and `out_val` drops.
- WAIT_RES: on `res_val`, the block pulses `log_val` next cycle with `log_frame` = current frame index and `log_class` = `res_class`. It then:
  - returns to IDLE if `stop` was latched since the pass started;
  - otherwise, if more frames remain in the pass, increments the frame index and enters PREFETCH;
  - otherwise, if `loop` was sampled high, wraps the frame index to 0 and enters PREFETCH;
  - otherwise returns to IDLE.
- `stop` is latched in any non-IDLE state and is never honoured mid-frame. The latch is cleared on entry to IDLE.
- `res_val` in any state other than WAIT_RES sets `err_unexp` and produces no log entry.
- Writes:
  - `wr_en` is honoured only in IDLE and is ignored while `busy`.
  - A write and an accepted `start` in the same cycle: the write is performed; streaming begins after it.
- Address arithmetic: read address = frame*`FRM_PIX` + pixel index. Pixel index wraps at `FRM_PIX`-1. No address past `N_FRAMES*FRM_PIX`-1 is ever generated.

## Timing
- Reset values: `out_val`=0, `out_data`=0, `out_sof`=0, `out_eof`=0, `log_val`=0, `log_frame`=0, `log_class`=0, `busy`=0, `err_unexp`=0, state IDLE.
- Buffer contents are not reset.
- Start latency: `start` at cycle N gives `busy`=1 at N+1 and the first `out_val` (with `out_sof`=1) at N+2.
- Throughput: with `out_rdy` held high, one frame occupies exactly `FRM_PIX` consecutive `out_val` cycles.
- Result latency: `res_val` at cycle M gives `log_val` at M+1 and the next frame's `out_sof` at M+3.
- `rst_n` asserted mid-frame aborts immediately. After release the block is in IDLE and `busy` is 0.

## Structure
- Shared package (`cnn_pkg`): the state encoding enum, the `IMG_W`/`IMG_H`/`PIX_W` defaults matching the CNN core, and the `CLS_W` default.
- One sub-module, `frame_buf_ram`: single-port-write/single-port-read synchronous RAM, depth `N_FRAMES*FRM_PIX`, width `PIX_W`, 1-cycle read latency, no reset.
- FSM, address counters and output register live in the top module.

## Test plan
- Ramp frame: load pixel i = i mod 256 into frame 0, `num_frames`=1, `out_rdy`=1 → 784 pixels 0x00..0xFF repeating, `out_sof` on pixel 0, `out_eof` on pixel 783; `res_val` with class 3 → `log_val`, `log_frame`=0, `log_class`=3, then IDLE.
- Back-pressure: toggle `out_rdy` pseudo-randomly → same 784-value sequence, no drops or duplicates, data stable during stalls.
- Multi-frame: 4 frames filled with 0x10/0x20/0x30/0x40, `num_frames`=4 → frames emitted in order, each only after the prior result, `log_frame` reads 0,1,2,3.
- Loop and stop: `loop`=1, `num_frames`=2; assert `stop` at pixel 100 of the 3rd frame (frame 0 again) → that frame completes, its result is logged, then IDLE.
- Errors and guards: `res_val` during STREAM → `err_unexp`=1; `start` with `num_frames`=0 → stays IDLE; `wr_en` while busy → buffer unchanged.
- Reset mid-stream at pixel 400 → all outputs 0 next cycle; a new `start` replays the frame from pixel 0.
